// File: rtl/reg_write_pkg.sv
// Shared types and constants for the register-file writeback stage.
package reg_write_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int RADDR_MAX = 8;

    localparam logic [1:0] SRC_MEM = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;
    localparam logic [1:0] SRC_CSR = 2'd3;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    typedef struct packed {
        logic [RADDR_MAX-1:0] rd;
        logic [XLEN_MAX-1:0]  data;
        logic                 wen;
    } entry_t;

endpackage

// File: rtl/reg_write_ld_align.sv
// Sub-word load formatter: shift by byte offset, then
// truncate to the access size and zero/sign extend.
module reg_write_ld_align
    import reg_write_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [OFFW-1:0] off,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sgn;
    int              nbits;

    always_comb begin
        sh = data >> {off, 3'b000};
        unique case (size)
            LD_B:    nbits = 8;
            LD_H:    nbits = 16;
            LD_W:    nbits = 32;
            default: nbits = XLEN;
        endcase
        // A double on a 32-bit datapath collapses to a word here.
        mask   = {XLEN{1'b1}} >> (XLEN - nbits);
        sgn    = ~uns & sh[nbits-1];
        result = (sh & mask) | ({XLEN{sgn}} & ~mask);
    end

endmodule

// File: rtl/reg_write_stage.sv
// Writeback stage: source select, load formatting, 2-entry
// skid buffer toward the register file, forwarding lookup.
module reg_write_stage
    import reg_write_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NSRC  = 4,
    parameter  int RADDR = 5,
    localparam int OFFW  = $clog2(XLEN / 8)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [1:0]           io_sel,
    input  logic [NSRC*XLEN-1:0] io_src,
    input  logic [RADDR-1:0]     io_rd,
    input  logic                 io_wen,
    input  logic [1:0]           io_ld_size,
    input  logic                 io_ld_unsigned,
    input  logic [OFFW-1:0]      io_ld_off,
    output logic                 io_wb_valid,
    input  logic                 io_wb_ready,
    output logic [RADDR-1:0]     io_wb_rd,
    output logic [XLEN-1:0]      io_wb_data,
    output logic                 io_wb_wen,
    input  logic [RADDR-1:0]     io_fwd_rs,
    output logic                 io_fwd_hit,
    output logic [XLEN-1:0]      io_fwd_data
);

    logic [1:0]      src_idx;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] res;
    entry_t          in_ent;

    reg_write_ld_align #(.XLEN(XLEN)) u_align (
        .data   (io_src[XLEN-1:0]),
        .size   (io_ld_size),
        .uns    (io_ld_unsigned),
        .off    (io_ld_off),
        .result (ld_data)
    );

    always_comb begin
        src_idx  = (32'(io_sel) < NSRC) ? io_sel : SRC_ALU;
        src_data = io_src[src_idx*XLEN +: XLEN];
        res      = (io_sel == SRC_MEM) ? ld_data : src_data;
        in_ent.rd   = RADDR_MAX'(io_rd);
        in_ent.data = XLEN_MAX'(res);
        in_ent.wen  = io_wen && (io_rd != '0);
    end

    entry_t     slot0;
    entry_t     slot1;
    entry_t     head;
    entry_t     young;
    logic       hd;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       wr_slot;

    assign io_in_ready = (count != 2'd2);
    assign io_wb_valid = (count != 2'd0);
    assign push        = io_in_valid && io_in_ready;
    assign pop         = io_wb_valid && io_wb_ready;
    assign wr_slot     = hd ^ (count != 2'd0);
    assign head        = hd ? slot1 : slot0;
    assign young       = hd ? slot0 : slot1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot0 <= '0;
            slot1 <= '0;
            hd    <= 1'b0;
            count <= 2'd0;
        end else if (io_flush) begin
            count <= 2'd0;
        end else begin
            if (push && wr_slot)  slot1 <= in_ent;
            if (push && !wr_slot) slot0 <= in_ent;
            if (pop) hd <= ~hd;
            if (push && !pop) count <= count + 2'd1;
            if (pop && !push) count <= count - 2'd1;
        end
    end

    assign io_wb_rd   = io_wb_valid ? head.rd[RADDR-1:0]  : '0;
    assign io_wb_data = io_wb_valid ? head.data[XLEN-1:0] : '0;
    assign io_wb_wen  = io_wb_valid && head.wen;

    logic rs_nz;
    logic hit_y;
    logic hit_h;

    assign rs_nz = (io_fwd_rs != '0);
    assign hit_y = (count == 2'd2) && young.wen && rs_nz
                && (young.rd[RADDR-1:0] == io_fwd_rs);
    assign hit_h = io_wb_valid && head.wen && rs_nz
                && (head.rd[RADDR-1:0] == io_fwd_rs);

    assign io_fwd_hit  = hit_y || hit_h;
    assign io_fwd_data = hit_y ? young.data[XLEN-1:0]
                       : hit_h ? head.data[XLEN-1:0] : '0;

    // Upper struct bits beyond the configured widths are never observed.
    logic unused_bits;
    assign unused_bits = ^{slot0, slot1};

endmodule

// File: tb/tb_reg_write_stage.sv
// Directed-vector bench for reg_write_stage at XLEN=32, NSRC=4.
module tb_reg_write_stage;

    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int RADDR = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 io_flush;
    logic                 io_in_valid;
    logic                 io_in_ready;
    logic [1:0]           io_sel;
    logic [NSRC*XLEN-1:0] io_src;
    logic [RADDR-1:0]     io_rd;
    logic                 io_wen;
    logic [1:0]           io_ld_size;
    logic                 io_ld_unsigned;
    logic [1:0]           io_ld_off;
    logic                 io_wb_valid;
    logic                 io_wb_ready;
    logic [RADDR-1:0]     io_wb_rd;
    logic [XLEN-1:0]      io_wb_data;
    logic                 io_wb_wen;
    logic [RADDR-1:0]     io_fwd_rs;
    logic                 io_fwd_hit;
    logic [XLEN-1:0]      io_fwd_data;

    int vecs = 0;
    int miss = 0;

    always #5 clock = ~clock;

    reg_write_stage #(.XLEN(XLEN), .NSRC(NSRC), .RADDR(RADDR)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_flush       (io_flush),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_sel         (io_sel),
        .io_src         (io_src),
        .io_rd          (io_rd),
        .io_wen         (io_wen),
        .io_ld_size     (io_ld_size),
        .io_ld_unsigned (io_ld_unsigned),
        .io_ld_off      (io_ld_off),
        .io_wb_valid    (io_wb_valid),
        .io_wb_ready    (io_wb_ready),
        .io_wb_rd       (io_wb_rd),
        .io_wb_data     (io_wb_data),
        .io_wb_wen      (io_wb_wen),
        .io_fwd_rs      (io_fwd_rs),
        .io_fwd_hit     (io_fwd_hit),
        .io_fwd_data    (io_fwd_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_flush       = 1'b0;
        io_in_valid    = 1'b0;
        io_sel         = 2'd1;
        io_rd          = '0;
        io_wen         = 1'b0;
        io_ld_size     = 2'd2;
        io_ld_unsigned = 1'b0;
        io_ld_off      = 2'd0;
        io_fwd_rs      = '0;
    endtask

    task automatic drain();
        io_in_valid = 1'b0;
        io_wb_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        io_wb_ready = 1'b0;
        idle();
        io_src = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        vecs++;
        if (io_wb_valid !== 1'b0 || io_wb_rd !== '0
            || io_wb_data !== '0 || io_wb_wen !== 1'b0) begin
            miss++;
            $display("FAIL reset_wb: v=%b rd=%0d d=%h w=%b want zeros",
                     io_wb_valid, io_wb_rd, io_wb_data, io_wb_wen);
        end
        vecs++;
        if (io_fwd_hit !== 1'b0 || io_fwd_data !== '0
            || io_in_ready !== 1'b1) begin
            miss++;
            $display("FAIL reset_fwd: hit=%b d=%h rdy=%b want 0/0/1",
                     io_fwd_hit, io_fwd_data, io_in_ready);
        end
        // Inputs ignored while reset is held.
        io_in_valid = 1'b1;
        io_rd       = 5'd2;
        tick();
        vecs++;
        if (io_wb_valid !== 1'b0) begin
            miss++;
            $display("FAIL reset_ignore: wb_valid=%b want 0", io_wb_valid);
        end
        idle();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_source_select();
        logic [31:0] exp [4];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        io_wb_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            io_in_valid = 1'b1;
            io_sel      = 2'(i);
            io_rd       = 5'(i + 1);
            io_wen      = 1'b1;
            tick();
            vecs++;
            if (io_wb_valid !== 1'b1 || io_wb_data !== exp[i]) begin
                miss++;
                $display("FAIL src_sel%0d: v=%b d=%h want 1/%h",
                         i, io_wb_valid, io_wb_data, exp[i]);
            end
        end
        drain();
        vecs++;
        if (io_wb_valid !== 1'b0) begin
            miss++;
            $display("FAIL src_drain: wb_valid=%b want 0", io_wb_valid);
        end
        idle();
    endtask

    task automatic test_load_format();
        logic [1:0]  sz  [7];
        logic        un  [7];
        logic [1:0]  of  [7];
        logic [1:0]  sl  [7];
        logic [31:0] exp [7];
        sz  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        un  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        of  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
        sl  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
        exp = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8000,
                32'h8000_F0A5, 32'h8000_F0A5, 32'h0080_00F0,
                32'h0000_0033};
        io_src = {32'h44, 32'h33, 32'h22, 32'h8000_F0A5};
        io_wb_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            io_in_valid    = 1'b1;
            io_sel         = sl[i];
            io_rd          = 5'd7;
            io_wen         = 1'b1;
            io_ld_size     = sz[i];
            io_ld_unsigned = un[i];
            io_ld_off      = of[i];
            tick();
            vecs++;
            if (io_wb_data !== exp[i]) begin
                miss++;
                $display("FAIL ld_fmt%0d: data=%h want %h",
                         i, io_wb_data, exp[i]);
            end
        end
        drain();
        idle();
        io_src = {32'h44, 32'h33, 32'h22, 32'h11};
    endtask

    task automatic test_backpressure();
        io_wb_ready = 1'b0;
        @(negedge clock);
        io_in_valid = 1'b1;
        io_wen      = 1'b1;
        io_sel      = 2'd1;
        io_rd       = 5'd3;
        tick();
        io_rd = 5'd4;
        tick();
        vecs++;
        if (io_in_ready !== 1'b0 || io_wb_rd !== 5'd3) begin
            miss++;
            $display("FAIL bp_full: rdy=%b rd=%0d want 0/3",
                     io_in_ready, io_wb_rd);
        end
        io_rd = 5'd6;
        tick();
        io_in_valid = 1'b0;
        vecs++;
        if (io_wb_rd !== 5'd3 || io_in_ready !== 1'b0) begin
            miss++;
            $display("FAIL bp_hold: rd=%0d rdy=%b want 3/0",
                     io_wb_rd, io_in_ready);
        end
        io_wb_ready = 1'b1;
        tick();
        vecs++;
        if (io_wb_rd !== 5'd4 || io_in_ready !== 1'b1
            || io_wb_valid !== 1'b1) begin
            miss++;
            $display("FAIL bp_drain1: rd=%0d rdy=%b v=%b want 4/1/1",
                     io_wb_rd, io_in_ready, io_wb_valid);
        end
        tick();
        vecs++;
        if (io_wb_valid !== 1'b0) begin
            miss++;
            $display("FAIL bp_drain2: wb_valid=%b want 0", io_wb_valid);
        end
        idle();
    endtask

    task automatic test_rd0_forward();
        io_wb_ready = 1'b0;
        @(negedge clock);
        io_in_valid = 1'b1;
        io_wen      = 1'b1;
        io_rd       = 5'd0;
        tick();
        io_in_valid = 1'b0;
        io_fwd_rs   = 5'd0;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b1 || io_wb_wen !== 1'b0
            || io_fwd_hit !== 1'b0) begin
            miss++;
            $display("FAIL rd0: v=%b wen=%b hit=%b want 1/0/0",
                     io_wb_valid, io_wb_wen, io_fwd_hit);
        end
        drain();
        io_wb_ready = 1'b0;
        @(negedge clock);
        io_src      = {32'h44, 32'h33, 32'hA, 32'h11};
        io_in_valid = 1'b1;
        io_rd       = 5'd5;
        io_fwd_rs   = 5'd5;
        #1;
        vecs++;
        if (io_fwd_hit !== 1'b0) begin
            miss++;
            $display("FAIL fwd_early: hit=%b want 0", io_fwd_hit);
        end
        tick();
        vecs++;
        if (io_fwd_hit !== 1'b1 || io_fwd_data !== 32'hA) begin
            miss++;
            $display("FAIL fwd_one: hit=%b d=%h want 1/a",
                     io_fwd_hit, io_fwd_data);
        end
        io_src = {32'h44, 32'h33, 32'hB, 32'h11};
        tick();
        io_in_valid = 1'b0;
        #1;
        vecs++;
        if (io_fwd_hit !== 1'b1 || io_fwd_data !== 32'hB) begin
            miss++;
            $display("FAIL fwd_young: hit=%b d=%h want 1/b",
                     io_fwd_hit, io_fwd_data);
        end
        io_fwd_rs = 5'd6;
        #1;
        vecs++;
        if (io_fwd_hit !== 1'b0 || io_fwd_data !== '0) begin
            miss++;
            $display("FAIL fwd_miss: hit=%b d=%h want 0/0",
                     io_fwd_hit, io_fwd_data);
        end
    endtask

    task automatic test_flush();
        // Buffer holds two entries from the forwarding test.
        @(negedge clock);
        io_flush    = 1'b1;
        io_in_valid = 1'b1;
        io_rd       = 5'd9;
        tick();
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b0 || io_in_ready !== 1'b1) begin
            miss++;
            $display("FAIL flush_full: v=%b rdy=%b want 0/1",
                     io_wb_valid, io_in_ready);
        end
        tick();
        vecs++;
        if (io_wb_valid !== 1'b0) begin
            miss++;
            $display("FAIL flush_push_drop: v=%b want 0", io_wb_valid);
        end
        @(negedge clock);
        io_in_valid = 1'b1;
        io_sel      = 2'd3;
        io_rd       = 5'd10;
        tick();
        io_in_valid = 1'b0;
        io_wb_ready = 1'b1;
        io_flush    = 1'b1;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b1 || io_wb_rd !== 5'd10
            || io_wb_data !== 32'h44) begin
            miss++;
            $display("FAIL flush_pop_bus: v=%b rd=%0d d=%h want 1/10/44",
                     io_wb_valid, io_wb_rd, io_wb_data);
        end
        tick();
        io_flush = 1'b0;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b0) begin
            miss++;
            $display("FAIL flush_pop_after: v=%b want 0", io_wb_valid);
        end
        idle();
    endtask

    task automatic test_async_reset();
        io_wb_ready = 1'b0;
        @(negedge clock);
        io_in_valid = 1'b1;
        io_wen      = 1'b1;
        io_rd       = 5'd12;
        tick();
        io_rd = 5'd13;
        tick();
        io_in_valid = 1'b0;
        io_fwd_rs   = 5'd13;
        #1;
        vecs++;
        if (io_in_ready !== 1'b0 || io_fwd_hit !== 1'b1) begin
            miss++;
            $display("FAIL ar_pre: rdy=%b hit=%b want 0/1",
                     io_in_ready, io_fwd_hit);
        end
        #1;
        reset = 1'b0;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b0 || io_fwd_hit !== 1'b0
            || io_wb_data !== '0 || io_in_ready !== 1'b1) begin
            miss++;
            $display("FAIL ar_now: v=%b hit=%b d=%h rdy=%b want 0/0/0/1",
                     io_wb_valid, io_fwd_hit, io_wb_data, io_in_ready);
        end
        @(negedge clock);
        reset       = 1'b1;
        io_in_valid = 1'b1;
        io_sel      = 2'd2;
        io_rd       = 5'd8;
        tick();
        io_in_valid = 1'b0;
        #1;
        vecs++;
        if (io_wb_valid !== 1'b1 || io_wb_rd !== 5'd8
            || io_wb_data !== 32'h33 || io_wb_wen !== 1'b1) begin
            miss++;
            $display("FAIL ar_after: v=%b rd=%0d d=%h w=%b want 1/8/33/1",
                     io_wb_valid, io_wb_rd, io_wb_data, io_wb_wen);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_source_select();
        test_load_format();
        test_backpressure();
        test_rd0_forward();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/reg_write_stage.md
# reg_write_stage

Parametrised register-file writeback stage that replaces the fixed three-way writeback multiplexer. It selects one of `NSRC` result sources, formats sub-word loads (byte/half/word/double, signed or unsigned, any byte offset) and queues the result in a 2-entry skid buffer. The buffer drives the register-file write port with a valid/ready handshake and exposes a combinational forwarding lookup. It sits between the memory-access stage and the register file.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `NSRC`, 4, number of result sources; legal range 3..4, source indices 0=MEM, 1=ALU, 2=PC4, 3=CSR.
- `RADDR`, 5, register address width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `io_flush` in 1: discards all buffered and incoming entries.
- `io_in_valid` in 1: input entry valid.
- `io_in_ready` out 1: stage can accept an entry.
- `io_sel` in 2: source select.
- `io_src` in NSRC*XLEN: packed sources; source k is at bits [k*XLEN +: XLEN].
- `io_rd` in RADDR: destination register.
- `io_wen` in 1: entry writes the register file.
- `io_ld_size` in 2: load size; 0=byte, 1=half, 2=word, 3=double.
- `io_ld_unsigned` in 1: zero-extend when set, sign-extend when clear.
- `io_ld_off` in log2(XLEN/8): byte offset of the load address.
- `io_wb_valid` out 1: head entry present.
- `io_wb_ready` in 1: register file accepts the head entry.
- `io_wb_rd` out RADDR: head entry destination register.
- `io_wb_data` out XLEN: head entry data.
- `io_wb_wen` out 1: head entry write enable.
- `io_fwd_rs` in RADDR: forwarding lookup address.
- `io_fwd_hit` out 1: a buffered entry matches `io_fwd_rs`.
- `io_fwd_data` out XLEN: data of the matching entry.

## Operation
- **Source select.** `io_sel` < NSRC selects that source. Any `io_sel` ≥ NSRC selects ALU (index 1).
- **Load formatting.** Applies only when `io_sel`==0; every other source passes through unchanged.
  - The data is shifted right by 8*`io_ld_off`, then the low 8/16/32/64 bits are taken and extended to XLEN.
  - Size 3 at XLEN=32 is treated as size 2.
  - Misaligned offsets are not trapped here. The shift is applied as-is, and bytes beyond the word boundary read as 0.
- **Entry formation.** An entry {rd, data, wen} is formed, and wen is forced to 0 when rd==0.
- **Buffer.** The buffer is 2 entries, FIFO order, with a count in 0..2.
  - `io_in_ready` = (count != 2). It is driven from the count register, not from `io_wb_ready`.
  - Push happens when `io_in_valid` && `io_in_ready`.
  - Pop happens when `io_wb_valid` && `io_wb_ready`.
  - Push and pop in the same cycle at count 1: count stays 1, the new entry becomes the head next cycle.
  - At count 2 no push is possible; a pop alone takes count to 1.
- **Head outputs.** `io_wb_valid` = (count != 0). `io_wb_rd`, `io_wb_data` and `io_wb_wen` show the head entry, and are driven 0 while `io_wb_valid`=0.
- **Forwarding.**
  - A hit requires a buffered entry with wen=1 and rd==`io_fwd_rs`. `io_fwd_rs`==0 never hits.
  - If both entries match, the youngest wins.
  - Lookup is combinational and considers registered entries only; the entry arriving in the current cycle is not visible.
- **Flush.**
  - `io_flush` sets count to 0 at the next edge.
  - Flush beats a simultaneous push: the incoming entry is dropped.
  - Flush beats a simultaneous pop: the pop completes on the bus this cycle and the rest of the buffer is cleared.

## Timing
- **Latency.** An entry accepted at edge T is visible on `io_wb_*` after T, one cycle of latency, when the buffer was empty. It appears in the `io_fwd_*` lookup from the same point.
- **Throughput.** One entry per cycle is sustained while `io_wb_ready`=1.
- **Reset.**
  - While `reset` is low: count=0, `io_wb_valid`=0, `io_wb_rd`=0, `io_wb_data`=0, `io_wb_wen`=0, `io_fwd_hit`=0, `io_fwd_data`=0.
  - `io_in_ready`=1 during reset, but inputs are ignored while `reset` is low.
- **Reset mid-operation.** Asserting reset mid-operation drops buffered entries immediately, without waiting for a clock edge.
- **Output stability.** `io_wb_*` are stable from the clock edge onward and change only after an edge with a pop, push or flush.

## Structure
- Package `reg_write_pkg` holds:
  - the source index constants SRC_MEM=0, SRC_ALU=1, SRC_PC4=2, SRC_CSR=3;
  - the load size constants LD_B=0, LD_H=1, LD_W=2, LD_D=3;
  - the entry struct {rd, data, wen}.
- Sub-module `reg_write_ld_align` is the purely combinational XLEN-parametrised formatter (data, size, unsigned, offset → XLEN result).
- The top level contains the select logic, the 2-entry buffer (two entry registers, a head pointer and a count) and the forwarding compare.

## Test plan
- **Source select.** XLEN=32, sources {MEM=0x11, ALU=0x22, PC4=0x33, CSR=0x44}, sel=0..3 in turn with `io_wb_ready`=1 → wb_data 0x11, 0x22, 0x33, 0x44, each one cycle after accept.
- **Load formatting.** MEM=0x8000_F0A5:
  - byte, off=0, signed → 0xFFFF_FFA5;
  - byte, off=1, unsigned → 0x0000_00F0;
  - half, off=2, signed → 0xFFFF_8000;
  - word → 0x8000_F0A5.
- **Backpressure.** Hold `io_wb_ready`=0 and push rd=3, then rd=4 → `io_in_ready`=0 after the second push, head rd=3. Release → rd=3 then rd=4 drain in order, `io_in_ready` back to 1.
- **rd==0 and forwarding.**
  - Push rd=0, wen=1 → `io_wb_wen`=0 and no fwd hit.
  - Push rd=5 data=0xA, then rd=5 data=0xB with wb stalled, lookup rs=5 → hit with 0xB.
- **Flush.**
  - Flush with count=2 plus a simultaneous push → count 0 next cycle and `io_wb_valid`=0.
  - Flush together with a pop at count=1 → the pop completes on the bus that cycle and nothing remains buffered afterwards.
- **Async reset.** Drop `reset` between clock edges with count=2 → `io_wb_valid`=0 and `io_fwd_hit`=0 immediately; after release, the first push is accepted normally.
